// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM generator sharing one frame counter.
// Each channel keeps a written target angle and a slew-limited current angle.
// The current angle steps toward the target once per frame, and the pulse
// width is reloaded only at the frame boundary, so pulses are never cut short
// or stretched partway through a frame.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   wr_en        target angle write strobe
//   wr_chan      channel index for the write (out-of-range writes are ignored)
//   wr_angle     requested angle in degrees, clamped to MAX_ANGLE
//   signal       PWM outputs, bit i drives servo i
//   frame_start  one-cycle pulse aligned with the rising edge of every pulse
//   settled      bit i high when channel i current angle equals its target
module servo_pwm_array #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MIN_PULSE     = 25000,
  parameter int unsigned STEP_PER_DEG  = 138,
  parameter int unsigned MAX_ANGLE     = 180,
  parameter int unsigned RESET_ANGLE   = 90,
  parameter int unsigned SLEW_DEG      = 0,
  localparam int unsigned CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CHAN_W-1:0]   wr_chan,
  input  logic [31:0]         wr_angle,
  output logic [CHANNELS-1:0] signal,
  output logic                frame_start,
  output logic [CHANNELS-1:0] settled
);

  localparam int unsigned     CNT_W       = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [7:0]      MAX_A       = 8'(MAX_ANGLE);
  localparam logic [7:0]      RESET_A     = 8'(RESET_ANGLE);
  localparam logic [31:0]     RESET_WIDTH = 32'(MIN_PULSE + STEP_PER_DEG * RESET_ANGLE);

  logic [CNT_W-1:0] count;
  logic [7:0]       target  [CHANNELS];
  logic [7:0]       cur     [CHANNELS];
  logic [31:0]      width   [CHANNELS];
  logic [7:0]       delta_c [CHANNELS];
  logic [7:0]       step_c  [CHANNELS];
  logic [7:0]       cur_nxt_c [CHANNELS];
  logic             boundary_c;
  logic             wr_hit_c;
  logic [7:0]       wr_clamped_c;

  // Frame boundary: last cycle of the frame
  always_comb begin
    boundary_c = (count == LAST_COUNT);
  end

  // Write qualification and 32-bit clamp of the requested angle
  always_comb begin
    wr_hit_c     = wr_en && (32'(wr_chan) < CHANNELS);
    wr_clamped_c = (wr_angle > 32'(MAX_ANGLE)) ? MAX_A : wr_angle[7:0];
  end

  // Slew step toward target; SLEW_DEG of 0 jumps straight to the target
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      delta_c[i]   = 8'd0;
      step_c[i]    = 8'd0;
      cur_nxt_c[i] = cur[i];
      delta_c[i]   = (target[i] > cur[i]) ? (target[i] - cur[i]) : (cur[i] - target[i]);
      step_c[i]    = ((SLEW_DEG == 0) || (32'(delta_c[i]) <= SLEW_DEG)) ? delta_c[i] : 8'(SLEW_DEG);
      cur_nxt_c[i] = (target[i] > cur[i]) ? (cur[i] + step_c[i]) : (cur[i] - step_c[i]);
    end
  end

  // Frame counter, per-channel state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      signal      <= '0;
      frame_start <= 1'b0;
      settled     <= '1;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        target[i] <= RESET_A;
        cur[i]    <= RESET_A;
        width[i]  <= RESET_WIDTH;
      end
    end else begin
      count       <= boundary_c ? '0 : (count + CNT_W'(1));
      frame_start <= (count == '0);
      for (int i = 0; i < int'(CHANNELS); i++) begin
        signal[i]  <= (32'(count) < width[i]);
        settled[i] <= (cur[i] == target[i]);
        // Boundary slew uses the pre-edge target, so a write on this edge waits a frame
        if (wr_hit_c && (wr_chan == CHAN_W'(i))) begin
          target[i] <= wr_clamped_c;
        end
        if (boundary_c) begin
          cur[i]   <= cur_nxt_c[i];
          width[i] <= 32'(MIN_PULSE) + 32'(STEP_PER_DEG) * 32'(cur_nxt_c[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench: two instances with a short 256-cycle frame.
// dut_a: 3 channels, no slew, reset angle 90 (width 110, max 200, min 20).
// dut_b: 2 channels, slew 10 deg/frame, reset angle 0 (width 20).
module tb_servo_pwm_array;

  localparam int P = 256;

  logic        clock;
  logic        reset;
  logic        wr_en_a, wr_en_b;
  logic [1:0]  wr_chan_a;
  logic [0:0]  wr_chan_b;
  logic [31:0] wr_angle_a, wr_angle_b;
  logic [2:0]  signal_a, settled_a;
  logic [1:0]  signal_b, settled_b;
  logic        frame_start_a, frame_start_b;

  int n_assert = 0;
  int n_fail   = 0;

  servo_pwm_array #(
    .CHANNELS(3), .PERIOD_CYCLES(P), .MIN_PULSE(20), .STEP_PER_DEG(1),
    .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_DEG(0)
  ) dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en_a), .wr_chan(wr_chan_a),
    .wr_angle(wr_angle_a), .signal(signal_a), .frame_start(frame_start_a),
    .settled(settled_a)
  );

  servo_pwm_array #(
    .CHANNELS(2), .PERIOD_CYCLES(P), .MIN_PULSE(20), .STEP_PER_DEG(1),
    .MAX_ANGLE(180), .RESET_ANGLE(0), .SLEW_DEG(10)
  ) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en_b), .wr_chan(wr_chan_b),
    .wr_angle(wr_angle_b), .signal(signal_b), .frame_start(frame_start_b),
    .settled(settled_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected dut_b ch0 width in frame n after target 180 is written during frame 1
  function automatic int bw(input int n);
    int d;
    d = 10 * (n - 1);
    if (d > 180) d = 180;
    return 20 + d;
  endfunction

  // Sample one full frame starting at its first negedge (frame_start high).
  // Optional write to dut_a at sample wk; optional dut_b ch0=180 write at sample 5.
  task automatic run_frame(input int n, input int ea0, input int ea1, input int ea2,
                           input int eb0, input int eb1, input logic eset_b,
                           input bit wa, input int wk, input logic [1:0] wch,
                           input logic [31:0] wang, input bit wb);
    int run_a[3], tot_a[3], run_b[2], tot_b[2];
    bit live_a[3], live_b[2];
    int fs_a, fs_b;
    int ea[3], eb[2];
    ea[0] = ea0; ea[1] = ea1; ea[2] = ea2; eb[0] = eb0; eb[1] = eb1;
    fs_a = 0; fs_b = 0;
    for (int c = 0; c < 3; c++) begin run_a[c] = 0; tot_a[c] = 0; live_a[c] = 1'b1; end
    for (int c = 0; c < 2; c++) begin run_b[c] = 0; tot_b[c] = 0; live_b[c] = 1'b1; end
    for (int k = 0; k < P; k++) begin
      if (k == 0) begin
        check($sformatf("F%0d frame_start_a", n), 32'(frame_start_a), 32'd1);
        check($sformatf("F%0d settled_b0", n), 32'(settled_b[0]), 32'(eset_b));
      end
      if (frame_start_a) fs_a++;
      if (frame_start_b) fs_b++;
      for (int c = 0; c < 3; c++) begin
        if (signal_a[c]) begin tot_a[c]++; if (live_a[c]) run_a[c]++; end
        else live_a[c] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        if (signal_b[c]) begin tot_b[c]++; if (live_b[c]) run_b[c]++; end
        else live_b[c] = 1'b0;
      end
      wr_en_a    = wa && (k == wk);
      wr_chan_a  = wch;
      wr_angle_a = wang;
      wr_en_b    = wb && (k == 5);
      wr_chan_b  = 1'b0;
      wr_angle_b = 32'd180;
      @(negedge clock);
    end
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    check($sformatf("F%0d fs count a", n), 32'(fs_a), 32'd1);
    check($sformatf("F%0d fs count b", n), 32'(fs_b), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("F%0d a%0d run", n, c), 32'(run_a[c]), 32'(ea[c]));
      check($sformatf("F%0d a%0d total", n, c), 32'(tot_a[c]), 32'(ea[c]));
    end
    for (int c = 0; c < 2; c++) begin
      check($sformatf("F%0d b%0d run", n, c), 32'(run_b[c]), 32'(eb[c]));
      check($sformatf("F%0d b%0d total", n, c), 32'(tot_b[c]), 32'(eb[c]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    wr_chan_a  = 2'd0;
    wr_chan_b  = 1'b0;
    wr_angle_a = 32'd0;
    wr_angle_b = 32'd0;
    repeat (3) @(negedge clock);
    check("reset signal_a", 32'(signal_a), 32'd0);
    check("reset signal_b", 32'(signal_b), 32'd0);
    check("reset frame_start", 32'(frame_start_a), 32'd0);
    check("reset settled_a", 32'(settled_a), 32'b111);
    check("reset settled_b", 32'(settled_b), 32'b11);
    reset = 1'b0;
    @(negedge clock);
    check("edge1 signal_a", 32'(signal_a), 32'b111);
    check("edge1 signal_b", 32'(signal_b), 32'b11);

    // F1: defaults; dut_b ch0 target 180
    run_frame(1, 110, 110, 110, bw(1), 20, 1'b1, 1'b0, 0, 2'd0, 32'd0, 1'b1);
    // F2: mid-pulse write ch0=180, current frame unaffected
    run_frame(2, 110, 110, 110, bw(2), 20, 1'b0, 1'b1, 50, 2'd0, 32'd180, 1'b0);
    // F3: ch1=0 written on the boundary edge
    run_frame(3, 200, 110, 110, bw(3), 20, 1'b0, 1'b1, P - 2, 2'd1, 32'd0, 1'b0);
    // F4: boundary write not yet visible; ch2=181 clamps
    run_frame(4, 200, 110, 110, bw(4), 20, 1'b0, 1'b1, 10, 2'd2, 32'd181, 1'b0);
    // F5: ch1 now 0; ch2 at max; write ch2=0
    run_frame(5, 200, 20, 200, bw(5), 20, 1'b0, 1'b1, 10, 2'd2, 32'd0, 1'b0);
    // F6: write ch2=0xFFFFFFFF
    run_frame(6, 200, 20, 20, bw(6), 20, 1'b0, 1'b1, 10, 2'd2, 32'hFFFF_FFFF, 1'b0);
    // F7: out-of-range channel write
    run_frame(7, 200, 20, 200, bw(7), 20, 1'b0, 1'b1, 10, 2'd3, 32'd0, 1'b0);
    // F8: write ch1=180 exactly
    run_frame(8, 200, 20, 200, bw(8), 20, 1'b0, 1'b1, 10, 2'd1, 32'd180, 1'b0);
    // F9: write ch0=0x100, whose low byte alone would be 0
    run_frame(9, 200, 200, 200, bw(9), 20, 1'b0, 1'b1, 10, 2'd0, 32'h0000_0100, 1'b0);
    for (int n = 10; n <= 20; n++) begin
      run_frame(n, 200, 200, 200, bw(n), 20, (n >= 19), 1'b0, 0, 2'd0, 32'd0, 1'b0);
    end

    // Reset in the middle of a pulse
    repeat (20) @(negedge clock);
    check("pre-reset signal_a", 32'(signal_a), 32'b111);
    reset = 1'b1;
    #1;
    check("async reset signal_a", 32'(signal_a), 32'd0);
    check("async reset signal_b", 32'(signal_b), 32'd0);
    check("async reset settled_a", 32'(settled_a), 32'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("in reset %0d signal_a", i), 32'(signal_a), 32'd0);
      check($sformatf("in reset %0d frame_start", i), 32'(frame_start_a), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    run_frame(22, 110, 110, 110, 20, 20, 1'b1, 1'b0, 0, 2'd0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
